// File: rtl/divider_seq_if.sv
// rtl/divider_seq_if.sv - operand/result handshake bundle for divider_seq
interface divider_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             signed_op;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport slave (
    input  in_valid, dividend, divisor, signed_op, flush, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport master (
    output in_valid, dividend, divisor, signed_op, flush, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - iterative restoring divider, UNROLL quotient bits per cycle
module divider_seq #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  divider_seq_if.slave div_if
);
  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] dabs_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             sop_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH:0]   step_tmp;
  logic [WIDTH:0]   step_diff;
  logic             neg_quo;
  logic             neg_rem;

  always_comb begin
    a_abs   = (sop_q && a_q[WIDTH-1]) ? (ZERO - a_q) : a_q;
    b_abs   = (sop_q && b_q[WIDTH-1]) ? (ZERO - b_q) : b_q;
    neg_quo = sop_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    neg_rem = sop_q && a_q[WIDTH-1];
  end

  // The partial remainder stays below the divisor, so the top bit of the
  // WIDTH+1-bit difference is a clean borrow flag for the restore decision.
  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    step_tmp  = '0;
    step_diff = '0;
    for (int u = 0; u < UNROLL; u++) begin
      step_tmp  = {rem_d, quo_d[WIDTH-1]};
      step_diff = step_tmp - {1'b0, dabs_q};
      quo_d     = {quo_d[WIDTH-2:0], ~step_diff[WIDTH]};
      rem_d     = step_diff[WIDTH] ? step_tmp[WIDTH-1:0] : step_diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      dabs_q      <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      sop_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (div_if.flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_if.in_valid) begin
            a_q        <= div_if.dividend;
            b_q        <= div_if.divisor;
            sop_q      <= div_if.signed_op;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= S_PREP;
          end
        end
        // Special results still pass through FIX (untouched there) so their
        // latency is a fixed two edges after acceptance.
        S_PREP: begin
          if (b_q == ZERO) begin
            quo_q   <= ONES;
            rem_q   <= a_q;
            dbz_q   <= 1'b1;
            state_q <= S_FIX;
          end else if (sop_q && (a_q == MIN_VAL) && (b_q == ONES)) begin
            quo_q   <= MIN_VAL;
            rem_q   <= ZERO;
            ovf_q   <= 1'b1;
            state_q <= S_FIX;
          end else begin
            quo_q   <= a_abs;
            rem_q   <= ZERO;
            dabs_q  <= b_abs;
            cnt_q   <= CW'(N - 1);
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_FIX: begin
          if (!dbz_q && !ovf_q) begin
            if (neg_quo) quo_q <= ZERO - quo_q;
            if (neg_rem) rem_q <= ZERO - rem_q;
          end
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (div_if.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign div_if.in_ready    = in_ready_q;
  assign div_if.out_valid   = out_valid_q;
  assign div_if.quotient    = quo_q;
  assign div_if.remainder   = rem_q;
  assign div_if.div_by_zero = dbz_q;
  assign div_if.overflow    = ovf_q;
endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - scoreboard bench for divider_seq (UNROLL=1 directed, UNROLL=4 sweep)
module tb_divider_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_seq_if #(.WIDTH(32)) bus ();
  divider_seq_if #(.WIDTH(32)) bus4 ();

  divider_seq #(.WIDTH(32), .UNROLL(1)) dut  (.clk(clk), .rst_n(rst_n), .div_if(bus));
  divider_seq #(.WIDTH(32), .UNROLL(4)) dut4 (.clk(clk), .rst_n(rst_n), .div_if(bus4));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t        vecs [11];
  logic [65:0] exp_q [$];
  logic [65:0] exp4_q [$];
  int          n_chk = 0;
  int          n_miss = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [65:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) return {32'hFFFFFFFF, a, 2'b10};
    if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h80000000, 32'h0, 2'b01};
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r, 2'b00};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_miss++;
        $display("FAIL unexpected_result: got %h with nothing expected",
                 {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow});
      end else begin
        check("result", {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (exp4_q.size() == 0) begin
        n_chk++;
        n_miss++;
        $display("FAIL unexpected_result_u4: got %h with nothing expected",
                 {bus4.quotient, bus4.remainder, bus4.div_by_zero, bus4.overflow});
      end else begin
        check("result_u4", {bus4.quotient, bus4.remainder, bus4.div_by_zero, bus4.overflow}, exp4_q.pop_front());
      end
    end
  end

  task automatic issue(input vec_t v, input bit wait_res);
    int lat;
    @(negedge clk);
    check("in_ready_idle", 66'(bus.in_ready), 66'd1);
    bus.in_valid  = 1'b1;
    bus.dividend  = v.a;
    bus.divisor   = v.b;
    bus.signed_op = v.s;
    @(posedge clk);
    if (wait_res) exp_q.push_back({v.q, v.r, v.dbz, v.ovf});
    #1;
    bus.in_valid  = 1'b0;
    bus.dividend  = ~v.a;
    bus.divisor   = ~v.b;
    bus.signed_op = ~v.s;
    if (wait_res) begin
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
        @(posedge clk); #1;
        lat++;
      end
      check("latency", 66'(lat), 66'(v.lat));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("return_to_idle", 66'(bus.in_ready), 66'd1);
  endtask

  task automatic watch_quiet(input string name);
    logic seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    check(name, 66'(seen), 66'd0);
  endtask

  task automatic issue4(input logic [31:0] a, input logic [31:0] b, input logic s);
    int lat;
    int exp_lat;
    int n;
    exp_lat = (b == 32'h0 || (s && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 2 : 10;
    @(negedge clk);
    bus4.in_valid  = 1'b1;
    bus4.dividend  = a;
    bus4.divisor   = b;
    bus4.signed_op = s;
    @(posedge clk);
    exp4_q.push_back(ref_div(a, b, s));
    #1;
    bus4.in_valid  = 1'b0;
    bus4.dividend  = ~a;
    bus4.divisor   = ~b;
    lat = 0;
    while (!bus4.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency_u4", 66'(lat), 66'(exp_lat));
    n = 0;
    while (!bus4.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_miss++;
      $display("FAIL idle_timeout_u4: in_ready %b required 1", bus4.in_ready);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;

    bus.in_valid  = 1'b0; bus.flush  = 1'b0; bus.out_ready  = 1'b1;
    bus.dividend  = '0;   bus.divisor = '0;  bus.signed_op  = 1'b0;
    bus4.in_valid = 1'b0; bus4.flush = 1'b0; bus4.out_ready = 1'b1;
    bus4.dividend = '0;   bus4.divisor = '0; bus4.signed_op = 1'b0;

    vecs = '{
      '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 1'b0, 34},
      '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0, 34},
      '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 1'b0, 34},
      '{32'h1234,       32'd0,          1'b0, 32'hFFFFFFFF,   32'h1234,       1'b1, 1'b0, 2},
      '{32'h1234,       32'd0,          1'b1, 32'hFFFFFFFF,   32'h1234,       1'b1, 1'b0, 2},
      '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 1'b1, 2},
      '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0, 1'b0, 34},
      '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, 1'b0, 34},
      '{32'h80000000,   32'd1,          1'b1, 32'h80000000,   32'd0,          1'b0, 1'b0, 34},
      '{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF,   1'b0, 1'b0, 34},
      '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0, 1'b0, 34}
    };

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, 66'h0);
    check("reset_handshake", {64'h0, bus.in_ready, bus.out_valid}, 66'b10);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i], 1'b1);
      wait_idle();
    end

    // Result held under back-pressure
    bus.out_ready = 1'b0;
    issue(vecs[0], 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_outputs", {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, {32'd14, 32'd2, 2'b00});
      check("hold_handshake", {64'h0, bus.in_ready, bus.out_valid}, 66'b01);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_idle", {64'h0, bus.in_ready, bus.out_valid}, 66'b10);

    // Flush sampled at the edge ending CALC cycle 10
    issue(vecs[0], 1'b0);
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_idle", {64'h0, bus.in_ready, bus.out_valid}, 66'b10);
    watch_quiet("flush_no_result");

    // Flush beats acceptance in the same cycle
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_over_accept", {64'h0, bus.in_ready, bus.out_valid}, 66'b10);
    watch_quiet("flush_accept_no_result");

    // Asynchronous reset in the middle of CALC
    issue(vecs[0], 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, 66'h0);
    check("async_reset_handshake", {64'h0, bus.in_ready, bus.out_valid}, 66'b10);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("reset_no_result");

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 50 == 0) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      issue4(a, b, s);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 66'(exp_q.size() + exp4_q.size()), 66'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
    $finish;
  end
endmodule
